// File: rtl/psr_pkg.sv
// psr_pkg: shared types and constants for the processor status register.
//   cond_t          - 4-bit branch/jump condition codes
//   PSR_*           - bit positions of the flags inside psr {N,Z,F,L,C}
//   shadow_state_t  - one-deep interrupt shadow occupancy
package psr_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'd0,
        COND_NE = 4'd1,
        COND_CS = 4'd2,
        COND_CC = 4'd3,
        COND_HI = 4'd4,
        COND_LS = 4'd5,
        COND_LO = 4'd6,
        COND_HS = 4'd7,
        COND_GT = 4'd8,
        COND_LE = 4'd9,
        COND_LT = 4'd10,
        COND_GE = 4'd11,
        COND_FS = 4'd12,
        COND_FC = 4'd13,
        COND_UC = 4'd14,
        COND_NV = 4'd15
    } cond_t;

    localparam int PSR_C = 0;
    localparam int PSR_L = 1;
    localparam int PSR_F = 2;
    localparam int PSR_Z = 3;
    localparam int PSR_N = 4;

    typedef enum logic {
        SH_EMPTY = 1'b0,
        SH_FULL  = 1'b1
    } shadow_state_t;

endpackage

// File: rtl/psr_unit_cond_eval.sv
// psr_unit_cond_eval: combinational condition-code evaluator.
//   psr      in  5  flags {N,Z,F,L,C}
//   cond     in  4  condition code
//   condTrue out 1  1 when cond holds for psr
// Kept standalone so fetch-stage prediction can reuse it.
module psr_unit_cond_eval
    import psr_pkg::*;
(
    input  logic [4:0] psr,
    input  logic [3:0] cond,
    output logic       condTrue
);

    logic c, l, f, z, n;

    assign c = psr[PSR_C];
    assign l = psr[PSR_L];
    assign f = psr[PSR_F];
    assign z = psr[PSR_Z];
    assign n = psr[PSR_N];

    always_comb begin
        condTrue = 1'b0;
        case (cond)
            COND_EQ: condTrue = z;
            COND_NE: condTrue = !z;
            COND_CS: condTrue = c;
            COND_CC: condTrue = !c;
            COND_HI: condTrue = !l && !z;
            COND_LS: condTrue = l || z;
            COND_LO: condTrue = l;
            COND_HS: condTrue = !l;
            COND_GT: condTrue = !n && !z;
            COND_LE: condTrue = n || z;
            COND_LT: condTrue = n;
            COND_GE: condTrue = !n;
            COND_FS: condTrue = f;
            COND_FC: condTrue = !f;
            COND_UC: condTrue = 1'b1;
            COND_NV: condTrue = 1'b0;
            default: condTrue = 1'b0;
        endcase
    end

endmodule

// File: rtl/psr_unit.sv
// psr_unit: processor status register, condition evaluator and interrupt shadow.
//   clk, rst_n          clock / async active-low reset
//   C, L, F, Z, N       ALU flags of the instruction in execute
//   flagWrite, flagMask commit enable and per-flag mask {N,Z,F,L,C}
//   cond                condition code evaluated against registered psr
//   branchReq           request a registered branch decision
//   save, restore       interrupt entry / return shadow control
//   psr                 registered flags {N,Z,F,L,C}
//   condTrue            combinational cond evaluation (no ALU bypass)
//   branchValid/Taken   registered branch decision, one cycle after branchReq
//   shadowErr           sticky shadow misuse flag
//
// Shadow FSM
//   state    | meaning
//   ---------+------------------------------------------
//   SH_EMPTY | no saved PSR; save accepted, restore error
//   SH_FULL  | shadow holds PSR; restore accepted, save error
module psr_unit
    import psr_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       C,
    input  logic       L,
    input  logic       F,
    input  logic       Z,
    input  logic       N,
    input  logic       flagWrite,
    input  logic [4:0] flagMask,
    input  logic [3:0] cond,
    input  logic       branchReq,
    input  logic       save,
    input  logic       restore,
    output logic [4:0] psr,
    output logic       condTrue,
    output logic       branchValid,
    output logic       branchTaken,
    output logic       shadowErr
);

    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_FULL  = 1'b1;

    logic       state;
    logic [4:0] shadow;
    logic [4:0] flags;
    logic [4:0] psr_next;
    logic       do_save;
    logic       do_restore;
    logic       shadow_bad;

    assign flags = {N, Z, F, L, C};

    // Simultaneous save+restore is treated as a single illegal request.
    assign do_save    = save && !restore && (state == ST_EMPTY);
    assign do_restore = restore && !save && (state == ST_FULL);
    assign shadow_bad = (save && restore)
                      || (save && !restore && (state == ST_FULL))
                      || (restore && !save && (state == ST_EMPTY));

    always_comb begin
        psr_next = psr;
        if (do_restore)
            psr_next = shadow;
        else if (flagWrite)
            psr_next = (psr & ~flagMask) | (flags & flagMask);
    end

    psr_unit_cond_eval u_cond_eval (
        .psr      (psr),
        .cond     (cond),
        .condTrue (condTrue)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psr         <= '0;
            shadow      <= '0;
            state       <= ST_EMPTY;
            branchValid <= 1'b0;
            branchTaken <= 1'b0;
            shadowErr   <= 1'b0;
        end else begin
            psr         <= psr_next;
            branchValid <= branchReq;
            branchTaken <= branchReq && condTrue;
            if (do_save) begin
                shadow <= psr;
                state  <= ST_FULL;
            end else if (do_restore) begin
                state  <= ST_EMPTY;
            end
            if (shadow_bad)
                shadowErr <= 1'b1;
        end
    end

endmodule

// File: tb/tb_psr_unit.sv
module tb_psr_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       C, L, F, Z, N;
    logic       flagWrite;
    logic [4:0] flagMask;
    logic [3:0] cond;
    logic       branchReq, save, restore;
    logic [4:0] psr;
    logic       condTrue, branchValid, branchTaken, shadowErr;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    logic [4:0] m_psr, m_shadow;
    logic       m_full, m_err, m_bv, m_bt;

    always #5 clk = ~clk;

    psr_unit dut (
        .clk(clk), .rst_n(rst_n),
        .C(C), .L(L), .F(F), .Z(Z), .N(N),
        .flagWrite(flagWrite), .flagMask(flagMask), .cond(cond),
        .branchReq(branchReq), .save(save), .restore(restore),
        .psr(psr), .condTrue(condTrue),
        .branchValid(branchValid), .branchTaken(branchTaken),
        .shadowErr(shadowErr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Codes come in pairs: even = predicate, odd = its negation; 14/15 constant.
    function automatic logic ref_cond(input logic [4:0] p, input logic [3:0] c);
        logic cf, lf, ff, zf, nf;
        logic [6:0] base;
        {nf, zf, ff, lf, cf} = p;
        if (c == 4'd14) return 1'b1;
        if (c == 4'd15) return 1'b0;
        base = {ff, nf, !nf && !zf, lf, !lf && !zf, cf, zf};
        return base[c >> 1] ^ c[0];
    endfunction

    task automatic model_reset();
        m_psr = '0; m_shadow = '0; m_full = 0; m_err = 0; m_bv = 0; m_bt = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".psr"}, 32'(psr), 32'(m_psr));
        chk({tag, ".bv"}, 32'(branchValid), 32'(m_bv));
        chk({tag, ".bt"}, 32'(branchTaken), 32'(m_bt));
        chk({tag, ".err"}, 32'(shadowErr), 32'(m_err));
    endtask

    // Drive one cycle of inputs, check condTrue, clock, update model, check.
    task automatic cyc(input string tag, input logic fw, input logic [4:0] mask,
                       input logic [4:0] fl, input logic [3:0] cd,
                       input logic br, input logic sv, input logic rs);
        logic restoring;
        logic [4:0] old_psr;
        flagWrite = fw; flagMask = mask; {N, Z, F, L, C} = fl;
        cond = cd; branchReq = br; save = sv; restore = rs;
        #1;
        chk({tag, ".cond"}, 32'(condTrue), 32'(ref_cond(m_psr, cd)));
        old_psr = m_psr;
        restoring = 0;
        m_bv = br;
        m_bt = br && ref_cond(old_psr, cd);
        if (sv && rs) m_err = 1;
        else if (sv) begin
            if (m_full) m_err = 1;
            else begin m_shadow = old_psr; m_full = 1; end
        end else if (rs) begin
            if (!m_full) m_err = 1;
            else begin restoring = 1; m_full = 0; end
        end
        if (restoring) m_psr = m_shadow;
        else if (fw) m_psr = (old_psr & ~mask) | (fl & mask);
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset();
        rst_n = 0;
        model_reset();
        #2;
        @(negedge clk);
        rst_n = 1;
        #1;
    endtask

    initial begin
        flagWrite = 0; flagMask = 0; {N, Z, F, L, C} = 0;
        cond = 4'd1; branchReq = 0; save = 0; restore = 0;
        do_reset();
        check_outputs("reset");
        chk("reset.ne", 32'(condTrue), 32'd1);

        // Z only set
        cyc("wr_z", 1, 5'b11111, 5'b01000, 4'd0, 0, 0, 0);
        chk("wr_z.val", 32'(psr), 32'h08);
        cyc("eq", 0, 0, 0, 4'd0, 0, 0, 0);
        chk("eq.true", 32'(condTrue), 32'd1);
        cyc("ne", 0, 0, 0, 4'd1, 0, 0, 0);

        // masked single-bit write
        cyc("all1", 1, 5'b11111, 5'b11111, 4'd0, 0, 0, 0);
        cyc("mask_c", 1, 5'b00001, 5'b00000, 4'd3, 0, 0, 0);
        chk("mask_c.val", 32'(psr), 32'h1E);
        cyc("cc", 0, 0, 0, 4'd3, 0, 0, 0);

        // back-to-back branches on L
        cyc("set_l", 1, 5'b11111, 5'b00010, 4'd0, 0, 0, 0);
        cyc("br_lo", 0, 0, 0, 4'd6, 1, 0, 0);
        chk("br_lo.taken", 32'(branchTaken), 32'd1);
        cyc("br_hs", 0, 0, 0, 4'd7, 1, 0, 0);
        chk("br_hs.taken", 32'(branchTaken), 32'd0);
        cyc("br_off", 0, 0, 0, 4'd14, 0, 0, 0);

        // save / overwrite / restore (restore overrides flagWrite)
        cyc("set_n", 1, 5'b11111, 5'b10000, 4'd0, 0, 0, 0);
        cyc("save", 0, 0, 0, 4'd0, 0, 1, 0);
        cyc("clr", 1, 5'b11111, 5'b00000, 4'd0, 0, 0, 0);
        cyc("rest", 1, 5'b11111, 5'b00001, 4'd0, 0, 0, 1);
        chk("rest.val", 32'(psr), 32'h10);
        chk("rest.noerr", 32'(shadowErr), 32'd0);

        // error paths
        cyc("rest_empty", 0, 0, 0, 4'd0, 0, 0, 1);
        chk("rest_empty.err", 32'(shadowErr), 32'd1);
        do_reset();
        cyc("sv1", 0, 0, 0, 4'd0, 0, 1, 0);
        cyc("sv2", 1, 5'b00100, 5'b00100, 4'd0, 0, 1, 0);
        chk("sv2.err", 32'(shadowErr), 32'd1);
        do_reset();
        cyc("both", 1, 5'b11111, 5'b01010, 4'd0, 0, 1, 1);
        chk("both.err", 32'(shadowErr), 32'd1);

        // async reset while FULL and branchValid high
        do_reset();
        cyc("pre_rst", 1, 5'b11111, 5'b11111, 4'd14, 1, 1, 0);
        #2;
        rst_n = 0;
        model_reset();
        cond = 4'd1;
        #1;
        check_outputs("async_rst");
        chk("async_rst.ne", 32'(condTrue), 32'd1);
        @(negedge clk);
        rst_n = 1;
        #1;
        cyc("post_rst", 0, 0, 0, 4'd0, 0, 0, 1);  // EMPTY after reset -> error

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            cyc("rand", 1'($urandom), 5'($urandom), 5'($urandom), 4'($urandom),
                1'($urandom), $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
            if ($urandom_range(0, 60) == 0) do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
